// File: rtl/fast_serial_pkg.sv
// Shared types and constants for the fast-serial stream bridge.
package fast_serial_pkg;

    // Start bit + 8 data bits + channel bit.
    localparam int   FRAME_BITS = 10;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_CHAN
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_CHAN
    } rx_state_t;

    // Occupancy ports need one bit more than the pointers so that "full" is representable.
    function automatic int level_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/fast_serial_fifo.sv
// Synchronous show-ahead FIFO, depth 2^DEPTH_LOG2. Pointers wrap naturally;
// the occupancy counter distinguishes full from empty.
module fast_serial_fifo
    import fast_serial_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 9
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [WIDTH-1:0]                     push_data,
    input  logic                                 pop,
    output logic [WIDTH-1:0]                     head,
    output logic                                 empty,
    output logic                                 full,
    output logic [level_width(DEPTH_LOG2)-1:0]   level
);

    localparam int LW = level_width(DEPTH_LOG2);

    logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(2**DEPTH_LOG2));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; push and pop in one cycle leave level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/fast_serial_stream_bridge.sv
// FTDI fast-serial bridge: free-running FSCLK, framed TX and RX with channel bit,
// both directions buffered. Optional macro FAST_SERIAL_LOOPBACK_EN adds i_loopback,
// which feeds o_fsdi back into the RX sampler and forces CTS high.
//
// TX state | meaning (line level shown while in the state)
// TX_IDLE  | line idle high, waiting for data and CTS on an FSCLK fall
// TX_START | start bit (0) on the line
// TX_DATA  | data bits, LSB first
// TX_CHAN  | channel bit on the line, then back to idle
//
// RX state | meaning
// RX_IDLE  | hunting for a 0 sample (start bit)
// RX_DATA  | shifting in 8 data bits, LSB first
// RX_CHAN  | next sample is the channel bit; push or drop on overflow
module fast_serial_stream_bridge
    import fast_serial_pkg::*;
#(
    parameter int CLK_DIV         = 4,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    output logic                                       o_fsclk,
    output logic                                       o_fsdi,
    input  logic                                       i_fsdo,
    input  logic                                       i_fscts,
    input  logic [7:0]                                 i_tx_data,
    input  logic                                       i_tx_chan,
    input  logic                                       i_tx_valid,
    output logic                                       o_tx_ready,
    output logic [7:0]                                 o_rx_data,
    output logic                                       o_rx_chan,
    output logic                                       o_rx_valid,
    input  logic                                       i_rx_ready,
    output logic [level_width(FIFO_DEPTH_LOG2)-1:0]    o_tx_level,
    output logic [level_width(FIFO_DEPTH_LOG2)-1:0]    o_rx_level,
    output logic                                       o_rx_overflow,
`ifdef FAST_SERIAL_LOOPBACK_EN
    input  logic                                       i_loopback,
`endif
    input  logic                                       i_overflow_clr
);

    // The synchronised FSDO must settle before the rise strobe samples it.
    generate
        if (CLK_DIV < SYNC_STAGES + 1) begin : g_bad_clk_div
            $error("fast_serial_stream_bridge: CLK_DIV must be >= SYNC_STAGES+1");
        end
    endgenerate

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [SYNC_STAGES-1:0] fsdo_sync;
    logic [SYNC_STAGES-1:0] cts_sync;
    logic [DIV_W-1:0]       div_cnt;
    logic                   rise_stb;
    logic                   fall_stb;
    logic                   rx_bit;
    logic                   cts;

    tx_state_t tx_state, tx_state_nxt;
    logic [2:0] tx_idx, tx_idx_nxt;
    logic [8:0] tx_sh, tx_sh_nxt;
    logic       fsdi_nxt;
    logic       tx_pop;
    logic [8:0] tx_head;
    logic       tx_empty;
    logic       tx_full;

    rx_state_t rx_state, rx_state_nxt;
    logic [2:0] rx_idx, rx_idx_nxt;
    logic [7:0] rx_sh, rx_sh_nxt;
    logic       rx_push;
    logic       overflow_set;
    logic [8:0] rx_head;
    logic       rx_empty;
    logic       rx_full;

    // Input synchronisers; FSDO resets to the idle level so no false start is seen.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fsdo_sync <= '1;
            cts_sync  <= '0;
        end else begin
            fsdo_sync[0] <= i_fsdo;
            cts_sync[0]  <= i_fscts;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                fsdo_sync[i] <= fsdo_sync[i-1];
                cts_sync[i]  <= cts_sync[i-1];
            end
        end
    end

`ifdef FAST_SERIAL_LOOPBACK_EN
    assign rx_bit = i_loopback ? o_fsdi : fsdo_sync[SYNC_STAGES-1];
    assign cts    = i_loopback | cts_sync[SYNC_STAGES-1];
`else
    assign rx_bit = fsdo_sync[SYNC_STAGES-1];
    assign cts    = cts_sync[SYNC_STAGES-1];
`endif

    // Free-running FSCLK divider; strobes coincide with the new FSCLK level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            div_cnt  <= '0;
            o_fsclk  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt  <= '0;
            o_fsclk  <= ~o_fsclk;
            rise_stb <= ~o_fsclk;
            fall_stb <= o_fsclk;
        end else begin
            div_cnt  <= div_cnt + 1'b1;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
        end
    end

    fast_serial_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(9)) u_tx_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (i_tx_valid),
        .push_data ({i_tx_chan, i_tx_data}),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (o_tx_level)
    );

    assign o_tx_ready = ~tx_full;

    // TX state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            tx_idx   <= '0;
            tx_sh    <= '0;
            o_fsdi   <= IDLE_LEVEL;
        end else begin
            tx_state <= tx_state_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_sh    <= tx_sh_nxt;
            o_fsdi   <= fsdi_nxt;
        end
    end

    // TX next state: shift {chan, data} out LSB first, one bit per FSCLK fall.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_idx_nxt   = tx_idx;
        tx_sh_nxt    = tx_sh;
        fsdi_nxt     = o_fsdi;
        tx_pop       = 1'b0;
        if (fall_stb) begin
            case (tx_state)
                TX_IDLE: begin
                    fsdi_nxt = IDLE_LEVEL;
                    if (!tx_empty && cts) begin
                        tx_pop       = 1'b1;
                        tx_sh_nxt    = tx_head;
                        fsdi_nxt     = 1'b0;
                        tx_state_nxt = TX_START;
                    end
                end
                TX_START: begin
                    fsdi_nxt     = tx_sh[0];
                    tx_sh_nxt    = {1'b0, tx_sh[8:1]};
                    tx_idx_nxt   = '0;
                    tx_state_nxt = TX_DATA;
                end
                TX_DATA: begin
                    // After the last data bit the shifter holds the channel bit at bit 0.
                    fsdi_nxt  = tx_sh[0];
                    tx_sh_nxt = {1'b0, tx_sh[8:1]};
                    if (tx_idx == 3'(FRAME_BITS - 3)) tx_state_nxt = TX_CHAN;
                    else                              tx_idx_nxt   = tx_idx + 1'b1;
                end
                default: begin
                    fsdi_nxt     = IDLE_LEVEL;
                    tx_state_nxt = TX_IDLE;
                end
            endcase
        end
    end

    // RX state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_state <= RX_IDLE;
            rx_idx   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_sh    <= rx_sh_nxt;
        end
    end

    // RX next state: sample on FSCLK rise, push the frame or flag an overflow.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_idx_nxt   = rx_idx;
        rx_sh_nxt    = rx_sh;
        rx_push      = 1'b0;
        overflow_set = 1'b0;
        if (rise_stb) begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_bit == 1'b0) begin
                        rx_idx_nxt   = '0;
                        rx_state_nxt = RX_DATA;
                    end
                end
                RX_DATA: begin
                    rx_sh_nxt = {rx_bit, rx_sh[7:1]};
                    if (rx_idx == 3'(FRAME_BITS - 3)) rx_state_nxt = RX_CHAN;
                    else                              rx_idx_nxt   = rx_idx + 1'b1;
                end
                default: begin
                    if (rx_full) overflow_set = 1'b1;
                    else         rx_push      = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
            endcase
        end
    end

    fast_serial_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(9)) u_rx_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (rx_push),
        .push_data ({rx_bit, rx_sh}),
        .pop       (i_rx_ready),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (o_rx_level)
    );

    assign o_rx_valid = ~rx_empty;
    assign o_rx_chan  = rx_head[8];
    assign o_rx_data  = rx_head[7:0];

    // Sticky overflow flag; a set wins over a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)             o_rx_overflow <= 1'b0;
        else if (overflow_set)   o_rx_overflow <= 1'b1;
        else if (i_overflow_clr) o_rx_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_fast_serial_stream_bridge.sv
// Directed bench for fast_serial_stream_bridge (default parameters: FSCLK period 8 clocks).
module tb_fast_serial_stream_bridge;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       o_fsclk;
    logic       o_fsdi;
    logic       i_fsdo;
    logic       i_fscts;
    logic [7:0] i_tx_data;
    logic       i_tx_chan;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_chan;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic [4:0] o_tx_level;
    logic [4:0] o_rx_level;
    logic       o_rx_overflow;
    logic       i_overflow_clr;
`ifdef FAST_SERIAL_LOOPBACK_EN
    logic       i_loopback;
`endif

    int n_pass  = 0;
    int n_total = 0;

    fast_serial_stream_bridge dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_fsclk        (o_fsclk),
        .o_fsdi         (o_fsdi),
        .i_fsdo         (i_fsdo),
        .i_fscts        (i_fscts),
        .i_tx_data      (i_tx_data),
        .i_tx_chan      (i_tx_chan),
        .i_tx_valid     (i_tx_valid),
        .o_tx_ready     (o_tx_ready),
        .o_rx_data      (o_rx_data),
        .o_rx_chan      (o_rx_chan),
        .o_rx_valid     (o_rx_valid),
        .i_rx_ready     (i_rx_ready),
        .o_tx_level     (o_tx_level),
        .o_rx_level     (o_rx_level),
        .o_rx_overflow  (o_rx_overflow),
`ifdef FAST_SERIAL_LOOPBACK_EN
        .i_loopback     (i_loopback),
`endif
        .i_overflow_clr (i_overflow_clr)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Wait for o_fsclk to change to lvl (bounded).
    task automatic wait_fsclk(input logic lvl);
        logic prev;
        bit   seen;
        prev = o_fsclk;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(1);
            if (prev == !lvl && o_fsclk == lvl) seen = 1'b1;
            prev = o_fsclk;
        end
        if (!seen) check("fsclk_edge_timeout", 32'(0), 32'(1));
    endtask

    function automatic logic [9:0] frame(input logic [7:0] d, input logic c);
        return {c, d, 1'b0};
    endfunction

    task automatic push_tx(input logic [7:0] d, input logic c);
        i_tx_data  = d;
        i_tx_chan  = c;
        i_tx_valid = 1'b1;
        tick(1);
        i_tx_valid = 1'b0;
    endtask

    // Wait for a start bit, then sample o_fsdi on each FSCLK rise.
    task automatic capture_frame(output logic [9:0] bits);
        int k;
        k = 0;
        bits = '1;
        while (o_fsdi !== 1'b0 && k < 400) begin
            tick(1);
            k++;
        end
        if (k == 400) check("tx_start_timeout", 32'(0), 32'(1));
        for (int i = 0; i < 10; i++) begin
            wait_fsclk(1'b1);
            bits[i] = o_fsdi;
        end
    endtask

    // FTDI model: change i_fsdo just after each FSCLK fall.
    task automatic send_rx(input logic [7:0] d, input logic c);
        logic [9:0] bits;
        bits = frame(d, c);
        for (int i = 0; i < 10; i++) begin
            wait_fsclk(1'b0);
            i_fsdo = bits[i];
        end
        wait_fsclk(1'b0);
        i_fsdo = 1'b1;
    endtask

    task automatic pop_rx();
        i_rx_ready = 1'b1;
        tick(1);
        i_rx_ready = 1'b0;
    endtask

    logic [9:0]  bits;
    logic [7:0]  cts_data [3];
    logic        cts_chan [3];
    logic        seen_low;
    time         t0;

    initial begin
        i_reset        = 1'b1;
        i_fsdo         = 1'b1;
        i_fscts        = 1'b0;
        i_tx_data      = '0;
        i_tx_chan      = 1'b0;
        i_tx_valid     = 1'b0;
        i_rx_ready     = 1'b0;
        i_overflow_clr = 1'b0;
`ifdef FAST_SERIAL_LOOPBACK_EN
        i_loopback     = 1'b0;
`endif
        tick(3);
        check("rst_fsdi",     32'(o_fsdi),        32'(1));
        check("rst_fsclk",    32'(o_fsclk),       32'(0));
        check("rst_tx_ready", 32'(o_tx_ready),    32'(1));
        check("rst_rx_valid", 32'(o_rx_valid),    32'(0));
        check("rst_tx_level", 32'(o_tx_level),    32'(0));
        check("rst_rx_level", 32'(o_rx_level),    32'(0));
        check("rst_overflow", 32'(o_rx_overflow), 32'(0));
        i_reset = 1'b0;
        tick(5);

        // Single TX frame: 0xA5, channel B -> 0,1,0,1,0,0,1,0,1,1 then idle 1.
        i_fscts = 1'b1;
        push_tx(8'hA5, 1'b1);
        capture_frame(bits);
        check("tx_a5_frame", 32'(bits), 32'(10'b1101001010));
        wait_fsclk(1'b1);
        check("tx_a5_idle", 32'(o_fsdi), 32'(1));
        check("tx_a5_level", 32'(o_tx_level), 32'(0));

        wait_fsclk(1'b1);
        t0 = $time;
        wait_fsclk(1'b1);
        check("fsclk_period", 32'(($time - t0) / 10), 32'(8));

        // CTS hold-off then release of three frames.
        i_fscts = 1'b0;
        tick(4);
        cts_data[0] = 8'h11; cts_chan[0] = 1'b0;
        cts_data[1] = 8'h22; cts_chan[1] = 1'b1;
        cts_data[2] = 8'h80; cts_chan[2] = 1'b0;
        for (int f = 0; f < 3; f++) push_tx(cts_data[f], cts_chan[f]);
        seen_low = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (o_fsdi == 1'b0) seen_low = 1'b1;
        end
        check("cts_hold_fsdi", 32'(seen_low), 32'(0));
        check("cts_hold_level", 32'(o_tx_level), 32'(3));
        i_fscts = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture_frame(bits);
            check("cts_frame", 32'(bits), 32'(frame(cts_data[f], cts_chan[f])));
            wait_fsclk(1'b1);
            check("cts_idle_gap", 32'(o_fsdi), 32'(1));
        end
        check("cts_level_end", 32'(o_tx_level), 32'(0));

        // Single RX frame.
        send_rx(8'h3C, 1'b0);
        tick(2);
        check("rx_valid", 32'(o_rx_valid), 32'(1));
        check("rx_data",  32'(o_rx_data),  32'(8'h3C));
        check("rx_chan",  32'(o_rx_chan),  32'(0));
        check("rx_level", 32'(o_rx_level), 32'(1));
        pop_rx();
        check("rx_level_popped", 32'(o_rx_level), 32'(0));
        check("rx_valid_popped", 32'(o_rx_valid), 32'(0));

        // RX overflow: 17 frames into a 16-deep FIFO.
        for (int v = 0; v < 17; v++) begin
            send_rx(8'(v), v[0]);
            if (v == 15) check("ovf_not_yet", 32'(o_rx_overflow), 32'(0));
        end
        tick(2);
        check("ovf_level", 32'(o_rx_level), 32'(16));
        check("ovf_flag",  32'(o_rx_overflow), 32'(1));
        check("ovf_tx_ready_unaffected", 32'(o_tx_ready), 32'(1));
        for (int v = 0; v < 16; v++) begin
            check("drain_data", 32'(o_rx_data), 32'(v));
            check("drain_chan", 32'(o_rx_chan), 32'(v & 1));
            pop_rx();
        end
        check("drain_level", 32'(o_rx_level), 32'(0));
        check("drain_valid", 32'(o_rx_valid), 32'(0));
        check("ovf_sticky", 32'(o_rx_overflow), 32'(1));
        i_overflow_clr = 1'b1;
        tick(1);
        i_overflow_clr = 1'b0;
        check("ovf_cleared", 32'(o_rx_overflow), 32'(0));

`ifdef FAST_SERIAL_LOOPBACK_EN
        // Loopback: TX frame returns through the RX path, CTS pin ignored.
        i_fscts    = 1'b0;
        i_loopback = 1'b1;
        push_tx(8'h5A, 1'b1);
        begin
            int k;
            k = 0;
            while (o_rx_valid !== 1'b1 && k < 400) begin
                tick(1);
                k++;
            end
        end
        check("lb_valid", 32'(o_rx_valid), 32'(1));
        check("lb_data",  32'(o_rx_data),  32'(8'h5A));
        check("lb_chan",  32'(o_rx_chan),  32'(1));
        pop_rx();
        i_loopback = 1'b0;
        i_fscts    = 1'b1;
        tick(20);
`endif

        // Reset mid-frame with both FIFOs occupied.
        i_fscts = 1'b0;
        tick(4);
        push_tx(8'hC3, 1'b0);
        push_tx(8'h3C, 1'b1);
        send_rx(8'h77, 1'b1);
        tick(2);
        check("pre_rst_tx_level", 32'(o_tx_level), 32'(2));
        check("pre_rst_rx_level", 32'(o_rx_level), 32'(1));
        i_fscts = 1'b1;
        begin
            int k;
            k = 0;
            while (o_fsdi !== 1'b0 && k < 200) begin
                tick(1);
                k++;
            end
        end
        tick(12);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("mid_rst_fsdi",     32'(o_fsdi),        32'(1));
        check("mid_rst_fsclk",    32'(o_fsclk),       32'(0));
        check("mid_rst_tx_level", 32'(o_tx_level),    32'(0));
        check("mid_rst_rx_level", 32'(o_rx_level),    32'(0));
        check("mid_rst_tx_ready", 32'(o_tx_ready),    32'(1));
        check("mid_rst_rx_valid", 32'(o_rx_valid),    32'(0));
        check("mid_rst_overflow", 32'(o_rx_overflow), 32'(0));
        seen_low = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick(1);
            if (o_fsdi == 1'b0) seen_low = 1'b1;
        end
        check("post_rst_tx_quiet", 32'(seen_low), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
